alu_share_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer that time-shares one ALU instance between two clients, for example the main datapath and an address/branch-compare helper. It captures one requester's operation into operand registers, drives the shared ALU for one cycle, registers the result and returns it with a per-requester valid strobe. It sits between the requesters and a single ALU. It is purely a control and staging block and adds no arithmetic of its own.

---
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 tb/tb_alu_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU between two
// requesters. A grant captures the winner's op/operands into the ALU drive
// registers (EXEC), the ALU result is registered at the end of EXEC and
// returned with a per-requester valid strobe (RESP).
module alu_share_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [2:0]  ALUControl0,
  input  logic [2:0]  ALUControl1,
  input  logic [31:0] SrcA0,
  input  logic [31:0] SrcB0,
  input  logic [31:0] SrcA1,
  input  logic [31:0] SrcB1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [2:0]  ALUControl,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  output logic [31:0] Result,
  output logic        ResultZero,
  output logic        ResultValid0,
  output logic        ResultValid1,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   prio;
  logic   owner;
  logic   grant;
  logic   winner;

  // Next-state and arbitration: requests count only in IDLE and RESP
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = (Req0 && Req1) ? prio : Req1;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (Req0 || Req1) begin
          grant     = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant edge: capture winner's op/operands, record owner, flip priority
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio       <= 1'b0;
      owner      <= 1'b0;
      ALUControl <= 3'd0;
      SrcA       <= 32'd0;
      SrcB       <= 32'd0;
    end else if (grant) begin
      prio       <= ~winner;
      owner      <= winner;
      ALUControl <= winner ? ALUControl1 : ALUControl0;
      SrcA       <= winner ? SrcA1 : SrcA0;
      SrcB       <= winner ? SrcB1 : SrcB0;
    end
  end

  // End of EXEC: register the shared ALU's combinational result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Result     <= 32'd0;
      ResultZero <= 1'b0;
    end else if (state == EXEC) begin
      Result     <= ALUResult;
      ResultZero <= Zero;
    end
  end

  // Handshake strobes are pure decodes of registered state and owner
  always_comb begin
    Ack0         = (state == EXEC) && !owner;
    Ack1         = (state == EXEC) &&  owner;
    ResultValid0 = (state == RESP) && !owner;
    ResultValid1 = (state == RESP) &&  owner;
    Busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus, a transaction-level schedule model
// checked every cycle, and literal expectations for each scenario.
module tb_alu_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [2:0]  ALUControl0 = 3'd0, ALUControl1 = 3'd0;
  logic [31:0] SrcA0 = 32'd0, SrcB0 = 32'd0, SrcA1 = 32'd0, SrcB1 = 32'd0;
  logic        Ack0, Ack1, ResultValid0, ResultValid1, Busy, ResultZero, Zero;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA, SrcB, ALUResult, Result;

  int checks = 0;
  int failures = 0;

  alu_share_arbiter dut (
    .CLK(CLK), .RST(RST), .Req0(Req0), .Req1(Req1),
    .ALUControl0(ALUControl0), .ALUControl1(ALUControl1),
    .SrcA0(SrcA0), .SrcB0(SrcB0), .SrcA1(SrcA1), .SrcB1(SrcB1),
    .Ack0(Ack0), .Ack1(Ack1), .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .ALUResult(ALUResult), .Zero(Zero), .Result(Result), .ResultZero(ResultZero),
    .ResultValid0(ResultValid0), .ResultValid1(ResultValid1), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Shared ALU stand-in
  always_comb begin
    ALUResult = alu_ref(ALUControl, SrcA, SrcB);
    Zero      = (ALUResult == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a grant at edge e means Ack in cycle e, ResultValid in
  // cycle e+1, and the next request can be sampled at edge e+2.
  int          cyc = 0;
  int          next_sample = 0;
  int          ack_at = -1;
  int          rv_at = -1;
  logic        m_who = 1'b0;
  logic        m_prio = 1'b0;
  logic [2:0]  e_ctl;
  logic [31:0] e_a, e_b, e_res;
  logic        e_ack, e_rv;

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      next_sample = 0;
      ack_at = -1;
      rv_at = -1;
      m_prio = 1'b0;
    end else if (cyc >= next_sample) begin
      if (Req0 || Req1) begin
        m_who  = (Req0 && Req1) ? m_prio : Req1;
        m_prio = !m_who;
        e_ctl  = m_who ? ALUControl1 : ALUControl0;
        e_a    = m_who ? SrcA1 : SrcA0;
        e_b    = m_who ? SrcB1 : SrcB0;
        e_res  = alu_ref(e_ctl, e_a, e_b);
        ack_at = cyc;
        rv_at  = cyc + 1;
        next_sample = cyc + 2;
      end else begin
        next_sample = cyc + 1;
      end
    end
  end

  // Event logs for the literal checks
  int          ack_q[$];
  logic        rv_who_q[$];
  logic [31:0] rv_res_q[$];
  logic        rv_z_q[$];

  // Per-cycle compare against the model, plus event logging
  always @(negedge CLK) begin
    if (RST) begin
      chk("reset_ctl", {56'd0, Ack0, Ack1, ResultValid0, ResultValid1, Busy, ResultZero, ALUControl[1:0]}, 64'd0);
      chk("reset_opnd", {SrcA, SrcB}, 64'd0);
      chk("reset_res", {32'd0, Result, 3'd0, ALUControl[2]}, 64'd0);
    end else begin
      e_ack = (ack_at == cyc);
      e_rv  = (rv_at == cyc);
      chk("handshake", {59'd0, Ack0, Ack1, ResultValid0, ResultValid1, Busy},
          {59'd0, e_ack && !m_who, e_ack && m_who, e_rv && !m_who, e_rv && m_who, e_ack || e_rv});
      if (e_ack) begin
        chk("alu_ctl", {61'd0, ALUControl}, {61'd0, e_ctl});
        chk("alu_opnd", {SrcA, SrcB}, {e_a, e_b});
      end
      if (e_rv) chk("result", {31'd0, Result, ResultZero}, {31'd0, e_res, e_res == 32'd0});
    end
    if (Ack0) ack_q.push_back(0);
    if (Ack1) ack_q.push_back(1);
    if (ResultValid0 || ResultValid1) begin
      rv_who_q.push_back(ResultValid1);
      rv_res_q.push_back(Result);
      rv_z_q.push_back(ResultZero);
    end
  end

  task automatic clear_logs();
    ack_q.delete(); rv_who_q.delete(); rv_res_q.delete(); rv_z_q.delete();
  endtask

  task automatic wait_ack(input logic who, input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((who == 1'b0 && Ack0) || (who == 1'b1 && Ack1)) return;
    end
    checks++;
    failures++;
    $display("FAIL %s ack timeout actual=none required=Ack%0d", name, who);
  endtask

  task automatic pin_rv(input int idx, input logic who, input logic [31:0] res, input logic z, input string name);
    if (idx >= rv_res_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s missing result actual=%0d results required>%0d", name, rv_res_q.size(), idx);
    end else begin
      chk(name, {30'd0, rv_who_q[idx], rv_res_q[idx], rv_z_q[idx]}, {30'd0, who, res, z});
    end
  endtask

  task automatic pin_acks(input int exp_q[$], input string name);
    chk({name, "_count"}, 64'(ack_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ack_q.size(); i++)
      chk(name, 64'(ack_q[i]), 64'(exp_q[i]));
  endtask

  task automatic drive0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl0 = op; SrcA0 = a; SrcB0 = b; Req0 = 1'b1;
  endtask

  task automatic drive1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl1 = op; SrcA1 = a; SrcB1 = b; Req1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_state", {59'd0, Ack0, Ack1, ResultValid0, ResultValid1, Busy}, 64'd0);
    RST = 1'b0;

    // Simultaneous requests after reset: requester 0 first
    clear_logs();
    drive0(3'b100, 32'd9, 32'd9);
    drive1(3'b001, 32'hF0, 32'h0F);
    wait_ack(1'b0, "simul_ack0");
    Req0 = 1'b0;
    wait_ack(1'b1, "simul_ack1");
    Req1 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_acks('{0, 1}, "simul_order");
    pin_rv(0, 1'b0, 32'd0, 1'b1, "simul_sub");
    pin_rv(1, 1'b1, 32'hFF, 1'b0, "simul_or");

    // Both requests held: strict alternation
    clear_logs();
    drive0(3'b010, 32'd1, 32'd1);
    drive1(3'b000, 32'hFF00, 32'h0FF0);
    repeat (8) @(negedge CLK);
    Req0 = 1'b0; Req1 = 1'b0;
    repeat (4) @(negedge CLK);
    pin_acks('{0, 1, 0, 1}, "held_order");
    pin_rv(0, 1'b0, 32'd2, 1'b0, "held_add");
    pin_rv(1, 1'b1, 32'h0F00, 1'b0, "held_and");

    // Single request, ADD
    clear_logs();
    drive0(3'b010, 32'd5, 32'd7);
    wait_ack(1'b0, "add_ack");
    Req0 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_rv(0, 1'b0, 32'd12, 1'b0, "add_result");
    chk("add_count", 64'(rv_res_q.size()), 64'd1);

    // SLT then MUL wrap from requester 1
    clear_logs();
    drive1(3'b110, 32'd3, 32'd4);
    wait_ack(1'b1, "slt_ack");
    Req1 = 1'b0;
    repeat (2) @(negedge CLK);
    drive1(3'b101, 32'h10000, 32'h10000);
    wait_ack(1'b1, "mul_ack");
    Req1 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_rv(0, 1'b1, 32'd1, 1'b0, "slt_result");
    pin_rv(1, 1'b1, 32'd0, 1'b1, "mul_wrap");

    // Invalid opcode passes through to the ALU
    clear_logs();
    drive0(3'b011, 32'd6, 32'd3);
    wait_ack(1'b0, "inv_ack");
    Req0 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_rv(0, 1'b0, 32'd0, 1'b1, "inv_result");

    // Reset during EXEC abandons the operation
    clear_logs();
    drive0(3'b010, 32'd1, 32'd2);
    wait_ack(1'b0, "rst_ack");
    #2;
    RST = 1'b1;
    Req0 = 1'b0;
    #1;
    chk("rst_now_ctl", {58'd0, Ack0, Ack1, ResultValid0, ResultValid1, Busy, ResultZero}, 64'd0);
    chk("rst_now_opnd", {SrcA, SrcB}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_no_result", 64'(rv_res_q.size()), 64'd0);

    // Priority back at 0: simultaneous requests serve requester 0 first
    clear_logs();
    drive0(3'b000, 32'hFF, 32'h0F);
    drive1(3'b001, 32'h100, 32'h1);
    wait_ack(1'b0, "post_ack0");
    Req0 = 1'b0;
    wait_ack(1'b1, "post_ack1");
    Req1 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_acks('{0, 1}, "post_order");
    pin_rv(0, 1'b0, 32'h0F, 1'b0, "post_and");
    pin_rv(1, 1'b1, 32'h101, 1'b0, "post_or");

    // Requester 1 alone after reset
    clear_logs();
    drive1(3'b010, 32'd40, 32'd2);
    wait_ack(1'b1, "solo1_ack");
    Req1 = 1'b0;
    repeat (3) @(negedge CLK);
    pin_rv(0, 1'b1, 32'd42, 1'b0, "solo1_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
